grayscale_frame_sequencer: RTL

- Sequences a full SIZE-row RGB frame through the fixed-latency row-parallel grayscale datapath.
- Issues row reads to the R/G/B row memories and tracks each row through memory and datapath latency with a tag pipeline.
- Raises the output-row write strobe and row address exactly when gray_arr_out holds that row.
- Sits between the frame buffers and the grayscale core; also provides start/abort/done control and a completed-frame counter.

---
 rtl/grayscale_frame_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/grayscale_frame_sequencer.sv
// Walks a SIZE-row RGB frame through the fixed-latency grayscale datapath.
// A {vld, row} tag pipeline follows each row read until its result is on gray_arr_out.
module grayscale_frame_sequencer #(
    parameter int SIZE   = 100,
    parameter int ROW_W  = $clog2(SIZE),
    parameter int RD_LAT = 1,
    parameter int DP_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [ROW_W-1:0] rd_row,
    output logic             dp_in_vld,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [15:0]      frame_cnt,
    output logic [1:0]       state_dbg
);

    localparam int D = RD_LAT + DP_LAT;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SIZE - 1);

    // IDLE is encoded as zero so a cleared state register reads as idle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rd_en_nxt;
    logic [ROW_W-1:0] rd_row_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [D-1:0]     tag_vld;
    logic [ROW_W-1:0] tag_row [D];

    // rd_en, dp_in_vld and wr_en are valid-only strobes: each marks one row in
    // the cycle it is high, and nothing downstream can stall the flow.
    assign dp_in_vld = tag_vld[RD_LAT-1];
    assign wr_en     = tag_vld[D-1];
    assign wr_row    = tag_row[D-1];
    assign state_dbg = state;

    always_comb begin
        state_nxt  = state;
        rd_row_nxt = rd_row;
        unique case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: if (rd_row == LAST_ROW) state_nxt = DRAIN;
            DRAIN: begin
                if (wr_en && (wr_row == LAST_ROW)) begin
                    state_nxt = DONE;
                end else if (tag_vld == '0) begin
                    state_nxt = IDLE;
                end
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;

        if (state_nxt == ISSUE) begin
            rd_row_nxt = (state == ISSUE) ? rd_row + 1'b1 : '0;
        end
        rd_en_nxt = (state_nxt == ISSUE);
        busy_nxt  = (state_nxt == ISSUE) || (state_nxt == DRAIN);
        done_nxt  = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_row    <= '0;
            frame_cnt <= '0;
            tag_vld   <= '0;
            for (int i = 0; i < D; i++) tag_row[i] <= '0;
        end else begin
            state  <= state_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            rd_en  <= rd_en_nxt;
            rd_row <= rd_row_nxt;
            if (done_nxt) frame_cnt <= frame_cnt + 16'd1;
            // Abort drops every in-flight row so no stray write follows.
            if (abort) tag_vld <= '0;
            else       tag_vld <= {tag_vld[D-2:0], rd_en};
            tag_row[0] <= rd_row;
            for (int i = 1; i < D; i++) tag_row[i] <= tag_row[i-1];
        end
    end

endmodule
